// File: rtl/bn_layer_pipe_if.sv
// Beat-level stream bundle for the batch-normalization pipe.
// The slave side is the BN block, and the master side is its upstream/downstream environment.
interface bn_layer_pipe_if #(
   parameter int LANES     = 2,
   parameter int WORD_SIZE = 16
);
   logic                       ready_o;
   logic                       valid_i;
   logic [LANES*WORD_SIZE-1:0] data_i;
   logic                       last_i;
   logic                       valid_o;
   logic                       ready_i;
   logic [LANES*WORD_SIZE-1:0] data_o;
   logic                       last_o;
   logic [LANES-1:0]           sat_o;
   logic                       err_o;

   modport slave (
      input  valid_i, data_i, last_i, ready_i,
      output ready_o, valid_o, data_o, last_o, sat_o, err_o
   );

   modport master (
      output valid_i, data_i, last_i, ready_i,
      input  ready_o, valid_o, data_o, last_o, sat_o, err_o
   );
endinterface

// File: rtl/bn_layer_pipe.sv
// Multi-lane batch-normalization pipe: y = sat(round(x*gain) + bias), optional ReLU, 2-cycle latency.
// Coefficient images are layer parameters; lane l of beat b uses channel b*LANES+l.
module ROM_neuron #(
   parameter int NEURON_NUMBER = 0,
   parameter int LANES         = 2,
   parameter int BEATS         = 4,
   parameter int ADDR_W        = 2,
   parameter int WORD_SIZE     = 16,
   parameter logic [BEATS*LANES*WORD_SIZE-1:0] IMAGE = '0
) (
   input  logic                        clk_i,
   input  logic [ADDR_W-1:0]           addr_i,
   output logic signed [WORD_SIZE-1:0] data_o
);
   localparam int LANE = NEURON_NUMBER / 2;

   logic [WORD_SIZE-1:0] mem [2**ADDR_W];

   for (genvar b = 0; b < 2**ADDR_W; b++) begin : g_word
      if (b < BEATS) begin : g_used
         assign mem[b] = IMAGE[(b*LANES+LANE)*WORD_SIZE +: WORD_SIZE];
      end else begin : g_pad
         assign mem[b] = '0;
      end
   end

   always_ff @(posedge clk_i) begin
      data_o <= mem[addr_i];
   end
endmodule

module bn_layer_pipe #(
   parameter int INPUT_SIZE   = 8,
   parameter int LANES        = 2,
   parameter int LAYER_NUMBER = 1,
   parameter int WORD_SIZE    = 16,
   parameter int N_SIZE       = 14,
   parameter int RELU_EN      = 0,
   parameter logic [INPUT_SIZE*WORD_SIZE-1:0] GAIN_ROM = {INPUT_SIZE{WORD_SIZE'(1 << N_SIZE)}},
   parameter logic [INPUT_SIZE*WORD_SIZE-1:0] BIAS_ROM = '0
) (
   input  logic         clk_i,
   input  logic         reset_i,
   bn_layer_pipe_if.slave bus
);
   localparam int BEATS  = INPUT_SIZE / LANES;
   localparam int ADDR_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int P_W    = 2 * WORD_SIZE;
   localparam int S_W    = P_W + 2;
   localparam logic [ADDR_W-1:0]       BEAT_MAX = ADDR_W'(BEATS - 1);
   localparam logic signed [S_W-1:0]   HALF     = S_W'(1) <<< (N_SIZE - 1);
   localparam logic signed [S_W-1:0]   SAT_HI   = S_W'((64'sd1 <<< (WORD_SIZE - 1)) - 64'sd1);
   localparam logic signed [S_W-1:0]   SAT_LO   = S_W'(-(64'sd1 <<< (WORD_SIZE - 1)));

   if (BEATS * LANES != INPUT_SIZE || LAYER_NUMBER < 1) begin : g_bad_cfg
      $error("bn_layer_pipe: INPUT_SIZE must be a multiple of LANES and LAYER_NUMBER must be >= 1");
   end

   // Round half up: add one half LSB of the result, then arithmetic shift.
   function automatic logic signed [S_W-1:0] round_prod(input logic signed [P_W-1:0] p);
      logic signed [S_W-1:0] t;
      t = S_W'(p) + HALF;
      return t >>> N_SIZE;
   endfunction

   function automatic logic [WORD_SIZE:0] sat_word(input logic signed [S_W-1:0] s);
      if (s > SAT_HI) return {1'b1, SAT_HI[WORD_SIZE-1:0]};
      if (s < SAT_LO) return {1'b1, SAT_LO[WORD_SIZE-1:0]};
      return {1'b0, s[WORD_SIZE-1:0]};
   endfunction

   logic                        stall, accept;
   logic [ADDR_W-1:0]           beat_q, beat_d, rom_addr;
   logic                        err_q, err_d;
   logic signed [WORD_SIZE-1:0] x_in     [LANES];
   logic signed [WORD_SIZE-1:0] gain_rom [LANES];
   logic signed [WORD_SIZE-1:0] bias_rom [LANES];

   logic                        vld_p1_q, last_p1_q;
   logic signed [P_W-1:0]       prod_p1_q [LANES];
   logic signed [WORD_SIZE-1:0] bias_p1_q [LANES];

   logic                        vld_p2_q, last_p2_q;
   logic [LANES*WORD_SIZE-1:0]  data_p2_q, data_p2_d;
   logic [LANES-1:0]            sat_p2_q, sat_p2_d;

   assign stall       = vld_p2_q && !bus.ready_i;
   assign accept      = bus.valid_i && !stall;
   assign bus.ready_o = !stall;

   // A last_i beat always closes the vector, even when it arrives early.
   always_comb begin
      beat_d = beat_q;
      err_d  = err_q;
      if (accept) begin
         beat_d = (bus.last_i || beat_q == BEAT_MAX) ? '0 : beat_q + ADDR_W'(1);
         if (bus.last_i != (beat_q == BEAT_MAX)) err_d = 1'b1;
      end
   end

   assign rom_addr = reset_i ? '0 : beat_d;

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      assign x_in[l] = $signed(bus.data_i[l*WORD_SIZE +: WORD_SIZE]);

      ROM_neuron #(
         .NEURON_NUMBER(2*l), .LANES(LANES), .BEATS(BEATS), .ADDR_W(ADDR_W),
         .WORD_SIZE(WORD_SIZE), .IMAGE(GAIN_ROM)
      ) u_gain (.clk_i(clk_i), .addr_i(rom_addr), .data_o(gain_rom[l]));

      ROM_neuron #(
         .NEURON_NUMBER(2*l+1), .LANES(LANES), .BEATS(BEATS), .ADDR_W(ADDR_W),
         .WORD_SIZE(WORD_SIZE), .IMAGE(BIAS_ROM)
      ) u_bias (.clk_i(clk_i), .addr_i(rom_addr), .data_o(bias_rom[l]));
   end

   // Stage 1 boundary: full-precision product, bias and framing captured on accept.
   always_ff @(posedge clk_i) begin
      if (accept) begin
         for (int l = 0; l < LANES; l++) begin
            prod_p1_q[l] <= P_W'(x_in[l]) * P_W'(gain_rom[l]);
            bias_p1_q[l] <= bias_rom[l];
         end
         last_p1_q <= bus.last_i;
      end
   end

   always_comb begin
      logic [WORD_SIZE:0] res;
      res       = '0;
      data_p2_d = '0;
      sat_p2_d  = '0;
      for (int l = 0; l < LANES; l++) begin
         res         = sat_word(round_prod(prod_p1_q[l]) + S_W'(bias_p1_q[l]));
         sat_p2_d[l] = res[WORD_SIZE];
         if (RELU_EN != 0 && res[WORD_SIZE-1]) res[WORD_SIZE-1:0] = '0;
         data_p2_d[l*WORD_SIZE +: WORD_SIZE] = res[WORD_SIZE-1:0];
      end
   end

   // Stage 2 boundary: normalized, saturated result; bubbles move valids but keep data.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         vld_p1_q  <= 1'b0;
         vld_p2_q  <= 1'b0;
         beat_q    <= '0;
         err_q     <= 1'b0;
         data_p2_q <= '0;
         last_p2_q <= 1'b0;
         sat_p2_q  <= '0;
      end else if (!stall) begin
         vld_p1_q <= accept;
         vld_p2_q <= vld_p1_q;
         beat_q   <= beat_d;
         err_q    <= err_d;
         if (vld_p1_q) begin
            data_p2_q <= data_p2_d;
            last_p2_q <= last_p1_q;
            sat_p2_q  <= sat_p2_d;
         end
      end
   end

   assign bus.valid_o = vld_p2_q;
   assign bus.data_o  = data_p2_q;
   assign bus.last_o  = last_p2_q;
   assign bus.sat_o   = sat_p2_q;
   assign bus.err_o   = err_q;
endmodule

// File: tb/tb_bn_layer_pipe.sv
// Bench for bn_layer_pipe: two instances (ReLU off/on) share one stimulus stream and a scoreboard
// fed by an arithmetic reference model of the normalization and framing rules.
module tb_bn_layer_pipe;
   localparam int W = 16, N = 14, LANES = 2, INPUT_SIZE = 8, BEATS = 4;

   // Channel c sits at [c*16 +: 16]: beat0 identity, beat1 x0.5, beat2 saturating, beat3 mixed.
   localparam logic [INPUT_SIZE*W-1:0] GAIN_P = {16'(-12000), 16'(8192), 16'(32767), 16'(32767),
                                                 16'(8192), 16'(8192), 16'(16384), 16'(16384)};
   localparam logic [INPUT_SIZE*W-1:0] BIAS_P = {16'(3000), 16'(-16384), 16'(-16384), 16'(16384),
                                                 16'(0), 16'(0), 16'(0), 16'(0)};
   int gain_tbl [INPUT_SIZE] = '{16384, 16384, 8192, 8192, 32767, 32767, 8192, -12000};
   int bias_tbl [INPUT_SIZE] = '{0, 0, 0, 0, 16384, -16384, -16384, 3000};

   typedef struct {
      logic [LANES*W-1:0] d_lin;
      logic [LANES*W-1:0] d_relu;
      logic               last;
      logic [LANES-1:0]   sat;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic valid = 1'b0, last = 1'b0, rdy = 1'b1;
   logic [LANES*W-1:0] din = '0;

   exp_t q[$];
   int   n_tests = 0, n_fail = 0, n_acc = 0, tb_beat = 0;
   bit   exp_err = 1'b0, prev_stall = 1'b0;
   logic [LANES*W-1:0] prev_d0, prev_d1;

   always #5 clk = ~clk;

   bn_layer_pipe_if #(.LANES(LANES), .WORD_SIZE(W)) if0 ();
   bn_layer_pipe_if #(.LANES(LANES), .WORD_SIZE(W)) if1 ();

   assign if0.valid_i = valid;
   assign if0.data_i  = din;
   assign if0.last_i  = last;
   assign if0.ready_i = rdy;
   assign if1.valid_i = valid;
   assign if1.data_i  = din;
   assign if1.last_i  = last;
   assign if1.ready_i = rdy;

   bn_layer_pipe #(.INPUT_SIZE(INPUT_SIZE), .LANES(LANES), .LAYER_NUMBER(1), .WORD_SIZE(W),
                   .N_SIZE(N), .RELU_EN(0), .GAIN_ROM(GAIN_P), .BIAS_ROM(BIAS_P))
      dut0 (.clk_i(clk), .reset_i(rst), .bus(if0));
   bn_layer_pipe #(.INPUT_SIZE(INPUT_SIZE), .LANES(LANES), .LAYER_NUMBER(1), .WORD_SIZE(W),
                   .N_SIZE(N), .RELU_EN(1), .GAIN_ROM(GAIN_P), .BIAS_ROM(BIAS_P))
      dut1 (.clk_i(clk), .reset_i(rst), .bus(if1));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // y = clamp(floor(x*g/2^N + 1/2) + b); ReLU variant zeroes negatives after the clamp.
   function automatic exp_t model_beat(input logic [LANES*W-1:0] x, input int beat, input logic lst);
      exp_t e;
      e.last = lst;
      for (int l = 0; l < LANES; l++) begin
         int     ch, xi;
         longint num, den, r, s;
         ch  = beat * LANES + l;
         xi  = $signed(x[l*W +: W]);
         den = longint'(1) << N;
         num = longint'(xi) * longint'(gain_tbl[ch]) + den / 2;
         r   = num / den;
         if ((num % den != 0) && (num < 0)) r = r - 1;
         s   = r + longint'(bias_tbl[ch]);
         e.sat[l] = (s > 32767) || (s < -32768);
         if (s > 32767) s = 32767;
         if (s < -32768) s = -32768;
         e.d_lin[l*W +: W]  = 16'(s);
         e.d_relu[l*W +: W] = (s < 0) ? 16'(0) : 16'(s);
      end
      return e;
   endfunction

   task automatic cycle();
      exp_t e;
      @(negedge clk);
      if (!rst) begin
         chk("ready_o", if0.ready_o, !(if0.valid_o && !rdy));
         chk("err_o", if0.err_o, exp_err);
         chk("err_o_relu", if1.err_o, exp_err);
         if (prev_stall) begin
            chk("hold_valid", if0.valid_o, 1'b1);
            chk("hold_data", if0.data_o, prev_d0);
            chk("hold_data_relu", if1.data_o, prev_d1);
         end
         if (if0.valid_o && rdy) begin
            if (q.size() == 0) chk("unexpected_beat", if0.valid_o, 1'b0);
            else begin
               e = q.pop_front();
               chk("data_o", if0.data_o, e.d_lin);
               chk("data_o_relu", if1.data_o, e.d_relu);
               chk("valid_o_relu", if1.valid_o, 1'b1);
               chk("last_o", if0.last_o, e.last);
               chk("sat_o", if0.sat_o, e.sat);
               chk("sat_o_relu", if1.sat_o, e.sat);
            end
         end
         if (valid && if0.ready_o) begin
            q.push_back(model_beat(din, tb_beat, last));
            if (last != (tb_beat == BEATS - 1)) exp_err = 1'b1;
            tb_beat = (last || tb_beat == BEATS - 1) ? 0 : tb_beat + 1;
            n_acc++;
         end
         prev_stall = if0.valid_o && !rdy;
         prev_d0    = if0.data_o;
         prev_d1    = if1.data_o;
      end
      @(posedge clk);
      #1;
      if (rst) begin
         q.delete();
         tb_beat    = 0;
         exp_err    = 1'b0;
         prev_stall = 1'b0;
      end
   endtask

   task automatic send(input int x0, input int x1, input logic lst);
      valid = 1'b1;
      din   = {16'(x1), 16'(x0)};
      last  = lst;
      cycle();
      valid = 1'b0;
      last  = 1'b0;
   endtask

   // Called two edges after send() with ready_i high: the beat must be on the output now.
   task automatic expect_out(input int e0, input int e1, input int r0, input int r1,
                             input logic [1:0] sat, input logic lst);
      logic [LANES*W-1:0] el, er;
      el = {16'(e1), 16'(e0)};
      er = {16'(r1), 16'(r0)};
      chk("lat_valid", if0.valid_o, 1'b1);
      chk("dir_data", if0.data_o, el);
      chk("dir_data_relu", if1.data_o, er);
      chk("dir_sat", if0.sat_o, sat);
      chk("dir_last", if0.last_o, lst);
   endtask

   task automatic do_reset();
      rst   = 1'b1;
      valid = 1'b0;
      last  = 1'b0;
      cycle();
      cycle();
      rst = 1'b0;
      chk("rst_valid_o", if0.valid_o, 1'b0);
      chk("rst_data_o", if0.data_o, '0);
      chk("rst_last_o", if0.last_o, 1'b0);
      chk("rst_sat_o", if0.sat_o, '0);
      chk("rst_err_o", if0.err_o, 1'b0);
      chk("rst_ready_o", if0.ready_o, 1'b1);
      chk("rst_valid_o_relu", if1.valid_o, 1'b0);
   endtask

   initial begin
      int cyc;
      do_reset();

      // One well-framed vector exercising identity, rounding, saturation and ReLU.
      send(8192, 8192, 1'b0);
      chk("lat_early", if0.valid_o, 1'b0);
      cycle();
      expect_out(8192, 8192, 8192, 8192, 2'b00, 1'b0);
      send(1, -1, 1'b0);
      cycle();
      expect_out(1, 0, 1, 0, 2'b00, 1'b0);
      send(16384, -32768, 1'b0);
      cycle();
      expect_out(32767, -32768, 32767, 0, 2'b11, 1'b0);
      send(100, 0, 1'b1);
      cycle();
      expect_out(-16334, 3000, 0, 3000, 2'b00, 1'b1);

      // Counter wrap, then an early last_i on beat 2 sets the sticky error.
      send(12345, -7, 1'b0);
      cycle();
      expect_out(12345, -7, 12345, 0, 2'b00, 1'b0);
      send(3, 3, 1'b0);
      cycle();
      expect_out(2, 2, 2, 2, 2'b00, 1'b0);
      send(0, 0, 1'b1);
      cycle();
      expect_out(16384, -16384, 16384, 0, 2'b00, 1'b1);
      chk("err_set", if0.err_o, 1'b1);
      send(8192, 8192, 1'b0);
      cycle();
      expect_out(8192, 8192, 8192, 8192, 2'b00, 1'b0);
      chk("err_sticky", if0.err_o, 1'b1);
      cycle();

      // Reset with two beats in flight; the next beat restarts at beat 0.
      do_reset();
      rdy = 1'b0;
      send(1000, 1000, 1'b0);
      send(2000, 2000, 1'b0);
      do_reset();
      rdy = 1'b1;
      send(8192, -8192, 1'b0);
      cycle();
      expect_out(8192, -8192, 8192, 0, 2'b00, 1'b0);

      // Random valid/ready over 1000 accepted beats with correct framing.
      n_acc = 0;
      cyc   = 0;
      while (n_acc < 1000 && cyc < 20000) begin
         valid = 1'($urandom_range(0, 1));
         rdy   = 1'($urandom_range(0, 1));
         din   = $urandom();
         last  = (tb_beat == BEATS - 1);
         cycle();
         cyc++;
      end
      chk("random_beats_accepted", n_acc >= 1000, 1'b1);
      valid = 1'b0;
      last  = 1'b0;
      rdy   = 1'b1;
      for (int i = 0; i < 10 && q.size() != 0; i++) cycle();
      chk("drained", q.size(), 0);
      chk("err_clean", if0.err_o, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
